// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
// Result appears with a one-cycle done pulse WIDTH cycles after an accepted start.
//
// state | meaning
// IDLE  | waiting for start, bcd holds last result
// SHIFT | one add-3/shift step per clock, busy high
// DONE  | one cycle, new result valid on bcd; start here chains the next conversion
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    sh;
  logic [4*DIGITS-1:0] scr;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] scr_nxt;

  // Correction and shift happen in the same cycle, so the shift uses the adjusted nibbles.
  always_comb begin
    adj = scr;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
    end
    scr_nxt = {adj[4*DIGITS-2:0], sh[WIDTH-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      scr   <= '0;
      bcd   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sh    <= bin;
            scr   <= '0;
            cnt   <= CW'(WIDTH);
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          scr <= scr_nxt;
          sh  <= {sh[WIDTH-2:0], 1'b0};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd   <= scr_nxt;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases, exhaustive sweep, random operands,
// busy-start rejection, back-to-back, mid-conversion reset and operand stability.
module tb_bin2bcd_seq;
  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [WIDTH-1:0]    bin = '0;
  logic                busy, done;
  logic [4*DIGITS-1:0] bcd;

  int tests = 0;
  int fails = 0;
  int prev_bcd = 0;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by divide/modulo, packed one per nibble.
  function automatic int model(int v);
    int r = 0;
    for (int d = 0; d < DIGITS; d++) begin
      r += (v % 10) << (4*d);
      v /= 10;
    end
    return r;
  endfunction

  task automatic check(string tag, int obs, int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call just before a rising edge (e.g. at a falling edge). Starts a conversion of v
  // and waits for done, checking latency, busy, held bcd and the final result.
  task automatic convert(int v, bit toggle_bin, bit fatal_on_bad);
    int k;
    int exp;
    exp = model(v);
    start = 1'b1;
    bin   = WIDTH'(v);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      if (toggle_bin) bin = WIDTH'($urandom);
      @(posedge clk); #1;
      if (done) begin
        k = c;
        break;
      end
      if (!fatal_on_bad) begin
        check("bcd_held", int'(bcd), prev_bcd);
        check("busy_during", int'(busy), 1);
      end
    end
    if (fatal_on_bad) begin
      tests++;
      assert (k == WIDTH && int'(bcd) === exp) else begin
        fails++;
        $display("FAIL sweep bin=%0d: observed %0h latency %0d expected %0h latency %0d",
                 v, bcd, k, exp, WIDTH);
        $fatal(1, "sweep stopped");
      end
    end else begin
      check("done_latency", k, WIDTH);
      check("result", int'(bcd), exp);
      check("busy_in_done", int'(busy), 0);
    end
    prev_bcd = exp;
  endtask

  initial begin
    int dones, d1, d2, b1, b2, v;

    // Reset state
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_bcd", int'(bcd), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed conversions; the first start lands on the first edge after reset release
    convert(0, 0, 0);
    @(negedge clk); convert(9, 0, 0);
    @(negedge clk); convert(10, 0, 0);
    @(negedge clk); convert(15, 0, 0);
    @(negedge clk); convert(255, 0, 0);
    @(negedge clk); @(negedge clk);
    check("idle_done_low", int'(done), 0);
    check("idle_bcd_held", int'(bcd), model(255));

    // Exhaustive sweep
    for (int i = 0; i < (1 << WIDTH); i++) begin
      @(negedge clk);
      convert(i, 0, 1);
    end

    // Random operands
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ($urandom_range(1, 0) == 0) @(negedge clk);
      convert(int'($urandom_range((1 << WIDTH) - 1, 0)), 0, 0);
    end

    // Start during SHIFT is ignored
    @(negedge clk); @(negedge clk);
    start = 1'b1; bin = 8'd200;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    start = 1'b1; bin = 8'd7;
    @(negedge clk);
    start = 1'b0; bin = 8'd0;
    dones = 0; b1 = -1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        b1 = int'(bcd);
      end
    end
    check("busy_start_dones", dones, 1);
    check("busy_start_bcd", b1, 'h200);

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1; bin = 8'd99;
    dones = 0; d1 = -1; d2 = -1; b1 = -1; b2 = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (c == 0) bin = 8'd100;
      if (done) begin
        dones++;
        if (dones == 1) begin d1 = c; b1 = int'(bcd); end
        else if (dones == 2) begin d2 = c; b2 = int'(bcd); end
      end
      if (dones == 1 && c == d1 + 1) start = 1'b0;
    end
    check("b2b_dones", dones, 2);
    check("b2b_spacing", d2 - d1, WIDTH + 1);
    check("b2b_first", b1, 'h099);
    check("b2b_second", b2, 'h100);

    // Reset mid-conversion
    @(negedge clk);
    start = 1'b1; bin = 8'd128;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_bcd", int'(bcd), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    prev_bcd = 0;
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_bcd_zero", int'(bcd), 0);
    @(negedge clk);
    convert(42, 0, 0);

    // Operand changes after accept are ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v = int'($urandom_range((1 << WIDTH) - 1, 0));
      convert(v, 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
